rr_arb_client_bank: RTL and testbench

- Requester-side counterpart of the round-robin arbiter: a bank of per-client pending-request counters that drives the arbiter's `request` vector and consumes its `grant` vector.
- Each client pushes request tokens. The bank holds `request[i]` high until the arbiter grants it, which is the arbiter's input contract.
- The bank detects protocol violations on the grant side.
- Sits between client logic and `rr_arbiter`, in formal and simulation environments.

---
 rtl/rr_arb_pkg.sv | 19 +
 rtl/rr_arb_client_slot.sv | 91 +++++++++
 rtl/rr_arb_client_bank.sv | 56 +++++
 tb/tb_rr_arb_client_bank.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types, defaults and helpers for the round-robin arbiter and its client bank.
package rr_arb_pkg;

  localparam int unsigned DefClients   = 32;
  localparam int unsigned DefDepth     = 4;
  localparam int unsigned DefWaitLimit = 31;

  // Upper bound on CLIENTS so grant vectors can be checked by one fixed-width helper.
  localparam int unsigned MaxClients   = 1024;

  typedef logic [DefClients-1:0] client_vec_t;
  typedef logic [MaxClients-1:0] wide_vec_t;

  // Clearing the lowest set bit leaves zero only for a zero or one-hot vector.
  function automatic logic is_zero_or_onehot(input wide_vec_t v);
    return (v & (v - wide_vec_t'(1))) == '0;
  endfunction

endpackage

// File: rtl/rr_arb_client_slot.sv
// One client's pending-token counter with full / push_drop flags.
// Optional wait counter and sticky starve flag under RR_ARB_CLIENT_STARVE_CHECK_EN.
module rr_arb_client_slot
  import rr_arb_pkg::*;
#(
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned WAIT_LIMIT = DefWaitLimit
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic grant,
  output logic request,
  output logic full,
  output logic push_drop,
  output logic starve
);

  localparam int unsigned     CntW   = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push_drop_q, push_drop_d;
  logic            take;

  assign request   = (cnt_q != '0);
  assign full      = (cnt_q == CntMax);
  assign push_drop = push_drop_q;

  // A grant only consumes a token when one is pending; stray grant bits are ignored here.
  assign take = grant & request;

  always_comb begin
    cnt_d       = cnt_q;
    push_drop_d = 1'b0;
    if (push && !take) begin
      if (full) begin
        push_drop_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end else if (take && !push) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      push_drop_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      push_drop_q <= push_drop_d;
    end
  end

`ifdef RR_ARB_CLIENT_STARVE_CHECK_EN
  localparam int unsigned      WaitW   = $clog2(WAIT_LIMIT + 2);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(WAIT_LIMIT + 1);
  localparam logic [WaitW-1:0] WaitOne = WaitW'(1);

  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             starve_q, starve_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!request || take) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WaitMax) begin
      wait_cnt_d = wait_cnt_q + WaitOne;
    end
    starve_d = starve_q | (wait_cnt_q == WaitMax);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      starve_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      starve_q   <= starve_d;
    end
  end

  assign starve = starve_q;
`else
  assign starve = 1'b0;
`endif

endmodule

// File: rtl/rr_arb_client_bank.sv
// Bank of per-client request counters feeding rr_arbiter, with grant protocol checking.
// Define RR_ARB_CLIENT_STARVE_CHECK_EN to build the per-client starvation monitors.
module rr_arb_client_bank
  import rr_arb_pkg::*;
#(
  parameter int unsigned CLIENTS    = DefClients,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned WAIT_LIMIT = DefWaitLimit
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CLIENTS-1:0] push,
  input  logic [CLIENTS-1:0] grant,
  output logic [CLIENTS-1:0] request,
  output logic [CLIENTS-1:0] full,
  output logic [CLIENTS-1:0] push_drop,
  output logic               grant_err,
  output logic [CLIENTS-1:0] starve
);

  for (genvar i = 0; i < CLIENTS; i++) begin : g_slot
    rr_arb_client_slot #(
      .DEPTH      (DEPTH),
      .WAIT_LIMIT (WAIT_LIMIT)
    ) u_slot (
      .clock     (clock),
      .reset     (reset),
      .push      (push[i]),
      .grant     (grant[i]),
      .request   (request[i]),
      .full      (full[i]),
      .push_drop (push_drop[i]),
      .starve    (starve[i])
    );
  end

  wide_vec_t grant_ext;
  logic      grant_err_q, grant_err_d;

  always_comb begin
    grant_ext              = '0;
    grant_ext[CLIENTS-1:0] = grant;
    grant_err_d = !is_zero_or_onehot(grant_ext) || (|(grant & ~request));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_err_q <= 1'b0;
    end else begin
      grant_err_q <= grant_err_d;
    end
  end

  assign grant_err = grant_err_q;

endmodule

// File: tb/tb_rr_arb_client_bank.sv
// Self-checking bench for rr_arb_client_bank: directed table, async reset, random vs model.
module tb_rr_arb_client_bank;

  localparam int unsigned CLIENTS    = 32;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned WAIT_LIMIT = 31;
`ifdef RR_ARB_CLIENT_STARVE_CHECK_EN
  localparam logic StarveOn = 1'b1;
`else
  localparam logic StarveOn = 1'b0;
`endif

  logic               clock;
  logic               reset;
  logic [CLIENTS-1:0] push;
  logic [CLIENTS-1:0] grant;
  logic [CLIENTS-1:0] request;
  logic [CLIENTS-1:0] full;
  logic [CLIENTS-1:0] push_drop;
  logic               grant_err;
  logic [CLIENTS-1:0] starve;

  rr_arb_client_bank #(
    .CLIENTS    (CLIENTS),
    .DEPTH      (DEPTH),
    .WAIT_LIMIT (WAIT_LIMIT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .grant     (grant),
    .request   (request),
    .full      (full),
    .push_drop (push_drop),
    .grant_err (grant_err),
    .starve    (starve)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests  = 0;
  int errors = 0;

  // Reference model: plain token counts per client.
  int                 m_cnt [CLIENTS];
  logic [CLIENTS-1:0] m_drop;
  logic               m_err;

  typedef struct {
    logic [CLIENTS-1:0] push;
    logic [CLIENTS-1:0] grant;
    logic [CLIENTS-1:0] req;
    logic [CLIENTS-1:0] full;
    logic [CLIENTS-1:0] drop;
    logic               err;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic [31:0] p, input logic [31:0] g, input logic [31:0] r,
                              input logic [31:0] f, input logic [31:0] d, input logic e);
    vec_t v;
    v.push = p; v.grant = g; v.req = r; v.full = f; v.drop = d; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CLIENTS-1:0] m_req();
    logic [CLIENTS-1:0] v;
    for (int i = 0; i < CLIENTS; i++) v[i] = (m_cnt[i] > 0);
    return v;
  endfunction

  function automatic logic [CLIENTS-1:0] m_full();
    logic [CLIENTS-1:0] v;
    for (int i = 0; i < CLIENTS; i++) v[i] = (m_cnt[i] == DEPTH);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CLIENTS; i++) m_cnt[i] = 0;
    m_drop = '0;
    m_err  = 1'b0;
  endtask

  // Apply one cycle of stimulus, advance the model, and land #1 after the clock edge.
  task automatic step(input logic [CLIENTS-1:0] p, input logic [CLIENTS-1:0] g);
    push  = p;
    grant = g;
    m_err = ($countones(g) > 1);
    for (int i = 0; i < CLIENTS; i++) begin
      bit legal;
      legal = g[i] && (m_cnt[i] > 0);
      if (g[i] && m_cnt[i] == 0) m_err = 1'b1;
      m_drop[i] = 1'b0;
      if (p[i] && !legal) begin
        if (m_cnt[i] < DEPTH) m_cnt[i]++;
        else m_drop[i] = 1'b1;
      end else if (legal && !p[i]) begin
        m_cnt[i]--;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".request"},   request,   m_req());
    check({tag, ".full"},      full,      m_full());
    check({tag, ".push_drop"}, push_drop, m_drop);
    check({tag, ".grant_err"}, {31'b0, grant_err}, {31'b0, m_err});
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    push  = '0;
    grant = '0;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    push  = '0;
    grant = '0;
    model_reset();

    tbl[0]  = mk(32'h10, 0, 32'h10, 0, 0, 0);
    tbl[1]  = mk(0, 0, 32'h10, 0, 0, 0);
    tbl[2]  = mk(0, 0, 32'h10, 0, 0, 0);
    tbl[3]  = mk(0, 32'h10, 0, 0, 0, 0);
    tbl[4]  = mk(32'h80, 0, 32'h80, 0, 0, 0);
    tbl[5]  = mk(32'h80, 0, 32'h80, 0, 0, 0);
    tbl[6]  = mk(32'h80, 0, 32'h80, 0, 0, 0);
    tbl[7]  = mk(32'h80, 0, 32'h80, 32'h80, 0, 0);
    tbl[8]  = mk(32'h80, 0, 32'h80, 32'h80, 32'h80, 0);
    tbl[9]  = mk(32'h80, 0, 32'h80, 32'h80, 32'h80, 0);
    tbl[10] = mk(0, 32'h80, 32'h80, 0, 0, 0);
    tbl[11] = mk(0, 32'h80, 32'h80, 0, 0, 0);
    tbl[12] = mk(0, 32'h80, 32'h80, 0, 0, 0);
    tbl[13] = mk(0, 32'h80, 0, 0, 0, 0);
    tbl[14] = mk(32'h04, 0, 32'h04, 0, 0, 0);
    tbl[15] = mk(32'h04, 0, 32'h04, 0, 0, 0);
    tbl[16] = mk(32'h04, 0, 32'h04, 0, 0, 0);
    tbl[17] = mk(32'h04, 0, 32'h04, 32'h04, 0, 0);
    tbl[18] = mk(32'h04, 32'h04, 32'h04, 32'h04, 0, 0);
    tbl[19] = mk(0, 32'h04, 32'h04, 0, 0, 0);
    tbl[20] = mk(32'h30, 0, 32'h34, 0, 0, 0);
    tbl[21] = mk(0, 32'h30, 32'h04, 0, 0, 1);
    tbl[22] = mk(0, 32'h200, 32'h04, 0, 0, 1);
    tbl[23] = mk(0, 0, 32'h04, 0, 0, 0);

    // Reset state, held across two clock edges.
    repeat (2) @(posedge clock);
    #1;
    check("rst.request",   request,   '0);
    check("rst.full",      full,      '0);
    check("rst.push_drop", push_drop, '0);
    check("rst.grant_err", {31'b0, grant_err}, '0);
    check("rst.starve",    starve,    '0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    for (int k = 0; k < 24; k++) begin
      string tag;
      tag = $sformatf("tbl%0d", k);
      step(tbl[k].push, tbl[k].grant);
      check({tag, ".request"},   request,   tbl[k].req);
      check({tag, ".full"},      full,      tbl[k].full);
      check({tag, ".push_drop"}, push_drop, tbl[k].drop);
      check({tag, ".grant_err"}, {31'b0, grant_err}, {31'b0, tbl[k].err});
    end
    step('0, '0);

    // Asynchronous reset mid-cycle with client 3 holding two tokens.
    step(32'h08, '0);
    step(32'h08, '0);
    check("pre_arst.request3", {31'b0, request[3]}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst.request", request, '0);
    check("arst.full",    full,    '0);
    model_reset();
    push  = '0;
    grant = '0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    step('0, '0);
    check("post_arst.request0", request, '0);
    step('0, '0);
    check("post_arst.request1", request, '0);

    // Randomized traffic against the model: dense pushes first, then draining.
    for (int c = 0; c < 600; c++) begin
      logic [CLIENTS-1:0] p, g;
      int                 r;
      if (c < 250) p = $urandom & $urandom & $urandom;
      else p = ($urandom_range(0, 3) == 0) ? (CLIENTS'(1) << $urandom_range(0, CLIENTS - 1)) : '0;
      g = '0;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        int start;
        start = $urandom_range(0, CLIENTS - 1);
        for (int j = 0; j < CLIENTS; j++) begin
          int idx;
          idx = (start + j) % CLIENTS;
          if (g == '0 && m_cnt[idx] > 0) g[idx] = 1'b1;
        end
      end else if (r == 6) begin
        g = $urandom;
      end else if (r == 7) begin
        g = CLIENTS'(1) << $urandom_range(0, CLIENTS - 1);
      end
      step(p, g);
      check_model($sformatf("rnd%0d", c));
`ifndef RR_ARB_CLIENT_STARVE_CHECK_EN
      check($sformatf("rnd%0d.starve", c), starve, '0);
`endif
    end

    // Starvation: client 0 waits unserved; flag appears 33 edges after its push edge.
    do_reset();
    step(32'h1, '0);
    for (int k = 0; k < 32; k++) step('0, '0);
    check("starve.before", {31'b0, starve[0]}, 32'd0);
    step('0, '0);
    check("starve.at33", {31'b0, starve[0]}, {31'b0, StarveOn});
    step('0, 32'h1);
    check_model("starve.grant");
    step('0, '0);
    check("starve.sticky", {31'b0, starve[0]}, {31'b0, StarveOn});
    check("starve.others", starve & ~32'h1, '0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
